// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        CHECK  = 3'd5,
        DONE   = 3'd6,
        ERR    = 3'd7
    } loader_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         LEN_W             = 16;

endpackage

// File: rtl/loader_word_asm.sv
// Collects four bytes into a little-endian word; "last" flags that the next
// accepted byte completes the word, and "word" already includes that byte.
module loader_word_asm (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last
);

    logic [1:0] idx_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx_reg <= 2'd0;
        end else if (load) begin
            idx_reg <= idx_reg + 2'd1;
        end
    end

    assign last = (idx_reg == 2'd3);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            logic       hit;

            assign hit = load && (idx_reg == 2'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg <= 8'd0;
                end else if (hit) begin
                    lane_reg <= byte_in;
                end
            end

            // Bypass the byte being accepted so the word is complete on the 4th byte.
            assign word[8*gi +: 8] = hit ? byte_in : lane_reg;
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream and writes it into instruction
// memory, holding the CPU in reset until done. IMEM_LOADER_CHECKSUM_EN adds an XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         IMEM_WORDS = 256,
    parameter int         ADDR_W     = 8,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              load_err
);

    loader_state_t     state_reg, state_next;
    logic [7:0]        len_lo_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [31:0]       imem_wdata_reg;
    logic              cpu_rst_reg, load_done_reg, load_err_reg;

    logic              accept;
    logic [LEN_W-1:0]  len_full;
    logic              last_word;
    logic [31:0]       asm_word;
    logic              asm_last;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_reg;
`endif

    assign rx_ready  = !rst && (state_reg != WRITE);
    assign accept    = rx_valid && rx_ready;
    assign len_full  = {rx_data, len_lo_reg};
    assign last_word = (cnt_reg == len_reg - LEN_W'(1));

    loader_word_asm u_word_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept && (state_reg == LEN_HI)),
        .load    (accept && (state_reg == DATA)),
        .byte_in (rx_data),
        .word    (asm_word),
        .last    (asm_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (accept && rx_data == SYNC_BYTE) state_next = LEN_LO;
            LEN_LO: if (accept) state_next = LEN_HI;
            LEN_HI: begin
                if (accept) begin
                    if (len_full == '0 || len_full > LEN_W'(IMEM_WORDS)) state_next = ERR;
                    else                                                   state_next = DATA;
                end
            end
            DATA:   if (accept && asm_last) state_next = WRITE;
            WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_next = last_word ? CHECK : DATA;
`else
                state_next = last_word ? DONE : DATA;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK:  if (accept) state_next = (rx_data == csum_reg) ? DONE : ERR;
`endif
            default: state_next = state_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            len_lo_reg     <= 8'd0;
            len_reg        <= '0;
            cnt_reg        <= '0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= 32'd0;
            cpu_rst_reg    <= 1'b1;
            load_done_reg  <= 1'b0;
            load_err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept && state_reg == LEN_LO) len_lo_reg <= rx_data;
            if (accept && state_reg == LEN_HI) begin
                len_reg <= len_full;
                cnt_reg <= '0;
            end
            // Write port registers load on the 4th byte so imem_we lines up with them.
            if (accept && state_reg == DATA && asm_last) begin
                imem_addr_reg  <= cnt_reg[ADDR_W-1:0];
                imem_wdata_reg <= asm_word;
            end
            if (state_reg == WRITE && !last_word) cnt_reg <= cnt_reg + LEN_W'(1);
            cpu_rst_reg   <= cpu_rst_reg && (state_reg != DONE);
            load_done_reg <= load_done_reg || (state_reg == DONE);
            load_err_reg  <= load_err_reg || (state_reg == ERR);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            csum_reg <= 8'd0;
        end else if (accept && state_reg == LEN_HI) begin
            csum_reg <= 8'd0;
        end else if (accept && state_reg == DATA) begin
            csum_reg <= csum_reg ^ rx_data;
        end
    end
`endif

    assign imem_we    = (state_reg == WRITE);
    assign imem_addr  = imem_addr_reg;
    assign imem_wdata = imem_wdata_reg;
    assign cpu_rst    = cpu_rst_reg;
    assign load_done  = load_done_reg;
    assign load_err   = load_err_reg;

endmodule
